// File: rtl/button_conditioner.sv
// Push-button front end: 2-FF synchronizer, per-channel debounce, and one-cycle
// press pulses with optional hold-to-repeat on masked channels.
module button_conditioner #(
    parameter int                 NUM_BTN         = 4,
    parameter int                 DEBOUNCE_CYCLES = 1000000,
    parameter int                 REPEAT_DELAY    = 50000000,
    parameter int                 REPEAT_RATE     = 10000000,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 4'b1100
) (
    input  logic               Clk100M,
    input  logic               Rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse
);

    localparam int DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE - 1);
    localparam logic [HOLD_W-1:0] HOLD_TOP   = HOLD_W'(HOLD_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_REPEAT
    } state_t;

    logic [NUM_BTN-1:0] sync_p0;
    logic [NUM_BTN-1:0] sync_p1;

    // Stage p0/p1: two-flop synchronizer, nothing between the flops.
    always_ff @(posedge Clk100M) begin
        if (Rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        logic [DEB_W-1:0]  deb_cnt;
        logic [HOLD_W-1:0] hold_cnt;
        logic              level_q;
        logic              pulse_q;
        logic              accept;
        logic              rise;
        logic              fall;
        state_t            state;

        // accept marks the edge on which the stable level takes the synced value
        assign accept = (sync_p1[i] != level_q) && (deb_cnt == DEB_LAST);
        assign rise   = accept && sync_p1[i];
        assign fall   = accept && !sync_p1[i];

        // Stage p2: debounced stable level.
        always_ff @(posedge Clk100M) begin
            if (Rst) begin
                deb_cnt <= '0;
                level_q <= 1'b0;
            end else if (sync_p1[i] == level_q) begin
                deb_cnt <= '0;
            end else if (accept) begin
                deb_cnt <= '0;
                level_q <= sync_p1[i];
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end

        // Stage p2: press/repeat FSM, pulse registered alongside the level.
        always_ff @(posedge Clk100M) begin
            if (Rst) begin
                state    <= ST_IDLE;
                hold_cnt <= '0;
                pulse_q  <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                case (state)
                    ST_IDLE: begin
                        if (rise) begin
                            pulse_q  <= 1'b1;
                            hold_cnt <= '0;
                            state    <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (fall) begin
                            state <= ST_IDLE;
                        end else if (REPEAT_MASK[i] && (hold_cnt == DELAY_LAST)) begin
                            pulse_q  <= 1'b1;
                            hold_cnt <= '0;
                            state    <= ST_REPEAT;
                        end else if (hold_cnt != HOLD_TOP) begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (fall) begin
                            state <= ST_IDLE;
                        end else if (hold_cnt == RATE_LAST) begin
                            pulse_q  <= 1'b1;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        hold_cnt <= '0;
                    end
                endcase
            end
        end

        assign btn_level[i] = level_q;
        assign btn_pulse[i] = pulse_q;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end for the user counter. Conditions the raw push-button inputs on Clk100M: 2-FF synchronizer, per-channel debounce, and single-cycle press pulses.
- Optional hold-to-repeat on selected channels, so a held up/down button steps the count repeatedly.
- Outputs drive the counter's start/stop/up/down inputs directly.
- Channel order: bit0 start, bit1 stop, bit2 up, bit3 down.

Parameters:
- NUM_BTN, 4, number of independent button channels.
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a synced input must differ from the stable state before it is accepted (10 ms at 100 MHz); must be >= 1.
- REPEAT_DELAY, 50000000, cycles from the press pulse to the first repeat pulse (0.5 s); must be >= 1.
- REPEAT_RATE, 10000000, cycles between subsequent repeat pulses (0.1 s); must be >= 1.
- REPEAT_MASK, 4'b1100, per-channel repeat enable (up/down only).

Ports:
- Clk100M  in  1  system clock, 100 MHz.
- Rst  in  1  synchronous reset, active-high.
- btn_raw  in  NUM_BTN  asynchronous raw button levels, 1 = pressed.
- btn_level  out  NUM_BTN  debounced stable button level.
- btn_pulse  out  NUM_BTN  one-cycle pulse on each accepted press and each repeat.

Behaviour:
- One clock, Clk100M. Reset is synchronous and active-high.
- While Rst is sampled high: sync FFs, stable state, all counters, FSMs, btn_level and btn_pulse clear to 0 on that edge.
- Synchronizer: btn_raw -> ff1 -> ff2 (synced). No logic between the two FFs.
- Debounce, per channel:
  - Counter width clog2(DEBOUNCE_CYCLES+1).
  - If synced == stable, the counter clears to 0.
  - If synced != stable, the counter increments each cycle.
  - On the DEBOUNCE_CYCLES-th consecutive differing cycle: stable <= synced, counter <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable. The counter restarts from 0 after any return to stable.
- Latency: raw change present before edge E0 first appears on btn_level at edge E0+DEBOUNCE_CYCLES+1. That is DEBOUNCE_CYCLES+2 edges counting E0.
- btn_level = stable, registered.
- Per-channel FSM (btn_pulse is registered and is high for exactly one cycle per event):
  - IDLE: on stable 0->1 (same edge btn_level rises), assert btn_pulse, clear the hold counter, go to WAIT.
  - WAIT:
    - Stable falls: go to IDLE, no pulse.
    - Else, when the hold counter reaches REPEAT_DELAY-1 and the REPEAT_MASK bit is set: pulse, clear counter, go to REPEAT.
    - With the mask bit clear, stay in WAIT with no pulses until release. The counter saturates and does not wrap.
  - REPEAT:
    - Stable falls: go to IDLE.
    - Else, each time the counter reaches REPEAT_RATE-1: pulse, clear counter.
- Pulse timing: with the press pulse at edge P, repeats occur at P+REPEAT_DELAY, then P+REPEAT_DELAY+k*REPEAT_RATE.
- Hold counter width: clog2(max(REPEAT_DELAY, REPEAT_RATE)+1).
- Release never generates a pulse. Press-release-press re-debounces normally.
- Channels are fully independent. Simultaneous presses on any channels produce pulses on the same edge; no arbitration.
- Reset mid-operation aborts any debounce or repeat. A button held through reset is seen as a new press after reset: synced = 1, stable = 0. It yields exactly one press pulse DEBOUNCE_CYCLES+2 edges after Rst deasserts, and repeat timing restarts from that pulse.

Test Plan:
All tests use NUM_BTN=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, REPEAT_MASK=4'b1100.
- Reset: Rst high 3 cycles with btn_raw=0 -> btn_level=0 and btn_pulse=0 from the first reset edge on.
- Clean press: btn_raw[0] rises before edge E0 and is held 20 cycles -> btn_level[0]=1 at E0+5, btn_pulse[0] high exactly 1 cycle at E0+5, no further pulses. Release -> btn_level[0]=0 six edges after the fall, no pulse.
- Bounce: btn_raw[1] pattern of 3 cycles high, 1 low, repeated 5 times -> no btn_level/btn_pulse change. Then held high -> single pulse 6 edges after the final rise.
- Repeat: btn_raw[2] held 30 cycles past press pulse P -> pulses at P, P+10, P+13, P+16, P+19, P+22, P+25, P+28 (8 total). Release -> pulses stop.
- Simultaneous: btn_raw[0] and btn_raw[1] rise on the same cycle -> btn_pulse=4'b0011 on one cycle, then 0.
- Reset mid-repeat: btn_raw[3] held, Rst pulsed 1 cycle after 2 repeats -> outputs 0 on the reset edge. Single press pulse 6 edges after Rst deasserts, next repeat 10 edges after that.
